// File: rtl/bcd_to_binary_pkg.sv
// bcd_pkg: shared types and constants for the packed-BCD to binary converter.
// Digit values above BCD_MAX_DIGIT are out of range for decimal encoding.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } bcd2bin_state_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // True when a digit cannot appear in a legal BCD encoding.
  function automatic logic digit_is_invalid(input bcd_digit_t digit);
    return (digit > BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if: request/result bundle of the BCD to binary converter.
// The master drives the load strobe and operand; the slave returns the result.
interface bcd_to_binary_if #(
  parameter int BINARY_WIDTH = 32,
  parameter int NUM_DIGITS   = 3
);
  import bcd_pkg::*;

  logic                                load;
  bcd_digit_t [NUM_DIGITS-1:0]         bcd_in;
  logic [BINARY_WIDTH-1:0]             binary_out;
  logic                                done;
  logic                                busy;
  logic                                invalid;

  modport master (
    output load, bcd_in,
    input  binary_out, done, busy, invalid
  );

  modport slave (
    input  load, bcd_in,
    output binary_out, done, busy, invalid
  );

endinterface

// File: rtl/bcd_mul10_add.sv
// bcd_mul10_add: combinational acc*10 + digit step, wrapping modulo 2^BINARY_WIDTH.
// The multiply is built from two shifts so no multiplier is inferred.
module bcd_mul10_add
  import bcd_pkg::*;
#(
  parameter int BINARY_WIDTH = 32
) (
  input  logic [BINARY_WIDTH-1:0] i_acc,
  input  bcd_digit_t              i_digit,
  output logic [BINARY_WIDTH-1:0] o_result
);

  assign o_result = (i_acc << 3) + (i_acc << 1) + BINARY_WIDTH'(i_digit);

endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: iterative packed-BCD to binary converter, one digit per cycle,
// most significant digit first. Optional digit range checking is enabled by
// defining BCD_DIGIT_CHECK_EN; without it the invalid output is tied low.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int BINARY_WIDTH = 32,
  parameter int NUM_DIGITS   = 3
) (
  input  logic            clk,
  input  logic            rst,
  bcd_to_binary_if.slave  bus
);

  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

  bcd2bin_state_t            r_state;
  logic [NUM_DIGITS*4-1:0]   r_digits;
  logic [BINARY_WIDTH-1:0]   r_acc;
  logic [BINARY_WIDTH-1:0]   r_binary_out;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_done;
  logic                      r_busy;

  bcd_digit_t                w_top_digit;
  logic [BINARY_WIDTH-1:0]   w_next_acc;
  logic                      w_last;

  assign w_top_digit = bcd_digit_t'(r_digits[NUM_DIGITS*4-1 -: 4]);
  assign w_last      = (r_state == CONVERT) && (r_cnt == CNT_LAST);

  bcd_mul10_add #(
    .BINARY_WIDTH (BINARY_WIDTH)
  ) u_mul10_add (
    .i_acc    (r_acc),
    .i_digit  (w_top_digit),
    .o_result (w_next_acc)
  );

  // Conversion FSM: capture on load, fold one digit per cycle, publish on the last digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_digits     <= '0;
      r_acc        <= '0;
      r_binary_out <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_digits <= bus.bcd_in;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CONVERT;
          end
        end
        CONVERT: begin
          r_acc    <= w_next_acc;
          r_digits <= r_digits << 4;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_binary_out <= w_next_acc;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic r_err;
  logic r_invalid;
  logic w_digit_err;

  assign w_digit_err = digit_is_invalid(w_top_digit);

  // Sticky digit-range error: cleared at load, accumulated per digit, published with done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err     <= 1'b0;
      r_invalid <= 1'b0;
    end else if ((r_state == IDLE) && bus.load) begin
      r_err <= 1'b0;
    end else if (r_state == CONVERT) begin
      r_err <= r_err | w_digit_err;
      if (w_last) begin
        r_invalid <= r_err | w_digit_err;
      end
    end
  end

  assign bus.invalid = r_invalid;
`else
  assign bus.invalid = 1'b0;
`endif

  assign bus.binary_out = r_binary_out;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: directed self-checking bench for bcd_to_binary.
// Honours BCD_DIGIT_CHECK_EN for the expected invalid flag.
module tb_bcd_to_binary;

`ifdef BCD_DIGIT_CHECK_EN
  localparam logic INV_EXP = 1'b1;
`else
  localparam logic INV_EXP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  bcd_to_binary_if #(.BINARY_WIDTH(32), .NUM_DIGITS(3)) bus32 ();
  bcd_to_binary_if #(.BINARY_WIDTH(8),  .NUM_DIGITS(3)) bus8 ();

  bcd_to_binary #(.BINARY_WIDTH(32), .NUM_DIGITS(3)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  bcd_to_binary #(.BINARY_WIDTH(8), .NUM_DIGITS(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge; ends at the falling edge of the done cycle with load low.
  task automatic conv(input logic [11:0] bcd, input logic [31:0] exp,
                      input logic exp_inv, input string tag);
    bus32.load   = 1'b1;
    bus32.bcd_in = bcd;
    @(posedge clk);
    @(negedge clk);
    bus32.load   = 1'b0;
    bus32.bcd_in = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check({tag, "_busy"},   32'(bus32.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus32.done), 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"},    32'(bus32.done),    32'd1);
    check({tag, "_idle"},    32'(bus32.busy),    32'd0);
    check({tag, "_out"},     bus32.binary_out,   exp);
    check({tag, "_invalid"}, 32'(bus32.invalid), 32'(exp_inv));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst          = 1'b0;
    bus32.load   = 1'b0;
    bus32.bcd_in = 12'h000;
    bus8.load    = 1'b0;
    bus8.bcd_in  = 12'h000;

    #20;
    check("rst_out",     bus32.binary_out,   32'd0);
    check("rst_done",    32'(bus32.done),    32'd0);
    check("rst_busy",    32'(bus32.busy),    32'd0);
    check("rst_invalid", 32'(bus32.invalid), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    conv(12'h011, 32'd11, 1'b0, "c011");
    @(negedge clk);
    check("c011_pulse", 32'(bus32.done), 32'd0);

    conv(12'h999, 32'd999, 1'b0, "c999");
    @(negedge clk);
    conv(12'h000, 32'd0, 1'b0, "c000");
    @(negedge clk);

    // Back-to-back: second load issued during the done cycle.
    conv(12'h123, 32'd123, 1'b0, "b2b1");
    conv(12'h456, 32'd456, 1'b0, "b2b2");
    @(negedge clk);
    check("b2b_pulse", 32'(bus32.done), 32'd0);

    // Load pulse mid-conversion must be ignored.
    bus32.load   = 1'b1;
    bus32.bcd_in = 12'h789;
    @(posedge clk);
    @(negedge clk);
    bus32.load = 1'b0;
    check("mid_busy0", 32'(bus32.busy), 32'd1);
    @(negedge clk);
    bus32.load   = 1'b1;
    bus32.bcd_in = 12'h111;
    @(negedge clk);
    bus32.load = 1'b0;
    check("mid_busy2", 32'(bus32.busy), 32'd1);
    @(negedge clk);
    check("mid_done", 32'(bus32.done), 32'd1);
    check("mid_out",  bus32.binary_out, 32'd789);
    @(negedge clk);
    check("mid_norestart_busy", 32'(bus32.busy), 32'd0);
    check("mid_norestart_done", 32'(bus32.done), 32'd0);

    // Non-decimal digit.
    conv(12'h0A5, 32'd105, INV_EXP, "c0a5");
    @(negedge clk);
    conv(12'h007, 32'd7, 1'b0, "c007");
    @(negedge clk);

    // Reset one cycle after load abandons the conversion.
    bus32.load   = 1'b1;
    bus32.bcd_in = 12'h555;
    @(posedge clk);
    @(negedge clk);
    bus32.load = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mrst_out",     bus32.binary_out,   32'd0);
    check("mrst_done",    32'(bus32.done),    32'd0);
    check("mrst_busy",    32'(bus32.busy),    32'd0);
    check("mrst_invalid", 32'(bus32.invalid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mrst_nodone", 32'(bus32.done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mrst_idle_done", 32'(bus32.done), 32'd0);
    conv(12'h042, 32'd42, 1'b0, "c042");
    @(negedge clk);

    // Narrow result width wraps modulo 256.
    bus8.load   = 1'b1;
    bus8.bcd_in = 12'h300;
    @(posedge clk);
    @(negedge clk);
    bus8.load = 1'b0;
    check("w8_busy", 32'(bus8.busy), 32'd1);
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("w8_done", 32'(bus8.done),  32'd1);
    check("w8_out",  32'(bus8.binary_out), 32'd44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Iterative packed-BCD to binary converter, the inverse of `SumOfNumbers2_10`. It accepts a `NUM_DIGITS`-digit packed BCD word on a `load` strobe and produces the equivalent unsigned binary value after `NUM_DIGITS` clock cycles. It consumes one digit per cycle, most significant digit first, using a multiply-by-10-and-add step. It sits on the input side of the arithmetic path, so that decimal operands entered or displayed by the system can be fed back into binary logic.

## Interface
- `BINARY_WIDTH`, 32: width of `binary_out`.
- `NUM_DIGITS`, 3: number of BCD digits in `bcd_in`; must be ≥1.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `load` in 1: start strobe, sampled on the rising edge of `clk`.
- `bcd_in` in `[NUM_DIGITS-1:0][3:0]`: packed BCD operand; digit `NUM_DIGITS-1` is the most significant.
- `binary_out` out `BINARY_WIDTH`: result, registered; holds its value until the next completion.
- `done` out 1: single-cycle completion pulse.
- `busy` out 1: high while a conversion is in progress.
- `invalid` out 1: digit-error flag, valid while `done` is high.

## Operation
- FSM with two states: IDLE and CONVERT.
- IDLE with `load`=1:
  - capture `bcd_in` into the digit shift register;
  - clear the accumulator to 0 and the digit counter to 0;
  - go to CONVERT.
- CONVERT, each cycle:
  - `acc <= (acc<<3) + (acc<<1) + top_digit`, computed in `BINARY_WIDTH` bits, wrapping modulo 2^`BINARY_WIDTH`;
  - shift the digit register left by 4;
  - increment the counter.
- Completing the cycle where counter = `NUM_DIGITS-1`:
  - `binary_out <= final acc`;
  - `done <= 1` for one cycle;
  - state returns to IDLE.
- `load` is ignored while in CONVERT. There is no abort; the captured operand is unaffected by later changes to `bcd_in`.
- `load` in the cycle where `done`=1 is accepted, because the FSM is already IDLE. This allows back-to-back conversions.
- Digits greater than 9 are used arithmetically as-is; see Configuration for flagging.
- No overflow flag: the result is truncated. The integrator sizes `BINARY_WIDTH` ≥ ceil(log2(10^`NUM_DIGITS`)).
- Reset mid-conversion: the conversion is abandoned. All outputs and state return to their reset values immediately; no `done` pulse is produced.

## Timing
- Reset values: `binary_out`=0, `done`=0, `busy`=0, `invalid`=0, state=IDLE, accumulator=0.
- `load` sampled high at edge k (in IDLE):
  - `busy`=1 from after edge k;
  - digits are processed at edges k+1 … k+`NUM_DIGITS`;
  - `binary_out` is valid and `done`=1 after edge k+`NUM_DIGITS`;
  - `busy`=0 in that same cycle.
- Latency is `NUM_DIGITS` cycles from the load edge. Throughput is one conversion per `NUM_DIGITS` cycles.
- `done` is high for exactly one cycle. `binary_out` is stable from that cycle until the next `done`.

## Configuration
- `BCD_DIGIT_CHECK_EN` defined:
  - each captured digit is compared against 9 as it is consumed;
  - a sticky error bit is cleared at load;
  - `invalid` equals that sticky bit and is updated together with `done`.
- Not defined:
  - the check logic is removed;
  - `invalid` is tied to 0;
  - the port still exists.

## Structure
- Shared package `bcd_pkg`:
  - `typedef logic [3:0] bcd_digit_t`;
  - FSM state enum `bcd2bin_state_t` {IDLE, CONVERT};
  - localparam `BCD_MAX_DIGIT` = 4'd9.
- One sub-module, `bcd_mul10_add`: combinational, parameterised by `BINARY_WIDTH`, computes `acc*10 + digit`. It is reusable for a future decimal accumulator.
- Counter width: `$clog2(NUM_DIGITS)`, with a minimum of 1.

## Test plan
- `rst` low for 20 ns, `bcd_in`=12'h011, `load` for one cycle → 3 cycles later `binary_out`=11 (0x0B) with `done`=1 for one cycle. `busy` is high exactly 3 cycles.
- `bcd_in`=12'h999 → `binary_out`=999. Then `bcd_in`=12'h000 → `binary_out`=0. `invalid`=0 in both cases.
- Back-to-back: 12'h123, then `load` held high during the `done` cycle with 12'h456 → `done` pulses twice, 3 cycles apart, giving 123 then 456. A `load` pulse mid-conversion is ignored.
- `bcd_in`=12'h0A5 → `binary_out`=105. `invalid`=1 only with `BCD_DIGIT_CHECK_EN`, otherwise 0. The next valid load clears `invalid`.
- Assert `rst` low one cycle after `load` → all outputs return to 0 immediately and no `done` is seen. After release, a new load of 12'h042 → 42.
- `BINARY_WIDTH`=8, `NUM_DIGITS`=3, `bcd_in`=12'h300 → `binary_out`=300 mod 256 = 44.
